pulse_train_analyzer: RTL

PULSE_TRAIN_ANALYZER -- requirements
Module: pulse_train_analyzer

---
 rtl/pulse_train_analyzer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pulse_train_analyzer.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_train_analyzer
//  Purpose  : Measures high time and rise-to-rise period of an asynchronous
//             pulse train in clk cycles. Reports results with a one-cycle
//             valid strobe, counts completed periods, flags timeouts and
//             keeps a sticky overflow flag for saturated measurements.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_train_analyzer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_valid,
  output logic [CNT_W-1:0] pulse_count,
  output logic             timeout,
  output logic             overflow
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Synchronizer and edge-detect flops
  logic             r_meta;
  logic             r_sync;
  logic             r_sync_d;

  // Measurement state
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt_hi;
  logic [CNT_W-1:0] r_cnt_per;
  logic [CNT_W-1:0] r_hi_len;

  // Result registers
  logic [CNT_W-1:0] r_meas_width;
  logic [CNT_W-1:0] r_meas_period;
  logic             r_meas_valid;
  logic [CNT_W-1:0] r_pulse_count;
  logic             r_timeout;
  logic             r_overflow;

  // Combinational helpers
  logic             w_rise;
  logic             w_fall;
  logic             w_per_sat;
  logic [CNT_W-1:0] w_cnt_hi_inc;
  logic [CNT_W-1:0] w_cnt_per_inc;

  // Two-flop synchronizer followed by a registered copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= pulse_in;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  // Edge detection and saturating increments
  always_comb begin
    w_rise        = r_sync & ~r_sync_d;
    w_fall        = ~r_sync & r_sync_d;
    w_per_sat     = (r_cnt_per == CNT_MAX);
    w_cnt_hi_inc  = (r_cnt_hi  == CNT_MAX) ? r_cnt_hi  : (r_cnt_hi  + CNT_ONE);
    w_cnt_per_inc = (r_cnt_per == CNT_MAX) ? r_cnt_per : (r_cnt_per + CNT_ONE);
  end

  // Measurement FSM: counters, result capture, strobes and status flags.
  // Both edges pass through the same synchronizer delay, so edge-to-edge
  // counts are unbiased by the detection latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt_hi      <= CNT_ZERO;
      r_cnt_per     <= CNT_ZERO;
      r_hi_len      <= CNT_ZERO;
      r_meas_width  <= CNT_ZERO;
      r_meas_period <= CNT_ZERO;
      r_meas_valid  <= 1'b0;
      r_pulse_count <= CNT_ZERO;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      // Strobes default low every cycle
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;

      if (!enable) begin
        // Disabled: drop any partial measurement, hold reported results
        r_state   <= ST_IDLE;
        r_cnt_hi  <= CNT_ZERO;
        r_cnt_per <= CNT_ZERO;
        r_hi_len  <= CNT_ZERO;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // A fresh enable starts a new session with clean status
            r_state       <= ST_ARM;
            r_overflow    <= 1'b0;
            r_pulse_count <= CNT_ZERO;
          end

          ST_ARM: begin
            // Only a full rising edge starts a measurement
            if (w_rise) begin
              r_state   <= ST_HIGH;
              r_cnt_hi  <= CNT_ONE;
              r_cnt_per <= CNT_ONE;
            end
          end

          ST_HIGH: begin
            if (w_per_sat) begin
              r_timeout  <= 1'b1;
              r_overflow <= 1'b1;
              r_state    <= ST_ARM;
              r_cnt_hi   <= CNT_ZERO;
              r_cnt_per  <= CNT_ZERO;
            end else begin
              r_cnt_hi  <= w_cnt_hi_inc;
              r_cnt_per <= w_cnt_per_inc;
              if (w_fall) begin
                r_hi_len <= r_cnt_hi;
                r_state  <= ST_LOW;
              end
            end
          end

          ST_LOW: begin
            if (w_per_sat) begin
              r_timeout  <= 1'b1;
              r_overflow <= 1'b1;
              r_state    <= ST_ARM;
              r_cnt_hi   <= CNT_ZERO;
              r_cnt_per  <= CNT_ZERO;
            end else if (w_rise) begin
              // Rise closes the current period and opens the next one
              r_meas_width  <= r_hi_len;
              r_meas_period <= r_cnt_per;
              r_meas_valid  <= 1'b1;
              r_pulse_count <= r_pulse_count + CNT_ONE;
              r_cnt_hi      <= CNT_ONE;
              r_cnt_per     <= CNT_ONE;
              r_state       <= ST_HIGH;
            end else begin
              r_cnt_per <= w_cnt_per_inc;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Output drive
  assign meas_width  = r_meas_width;
  assign meas_period = r_meas_period;
  assign meas_valid  = r_meas_valid;
  assign pulse_count = r_pulse_count;
  assign timeout     = r_timeout;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire
